// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word accesses into aligned word accesses on a
// big-endian data memory, with read-merge-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned DM_SIZE = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_read,
  output logic        dm_write,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [2:0] {StIdle, StRead, StMerge, StWrite, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;

  logic        cap_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Access legality is decided once, on the raw request, before any memory traffic.
  always_comb begin
    cap_err = 1'b0;
    unique case (size)
      2'b00:   cap_err = 1'b0;
      2'b01:   cap_err = addr[0];
      2'b10:   cap_err = |addr[1:0];
      default: cap_err = 1'b1;
    endcase
    if (addr >= DM_SIZE) cap_err = 1'b1;
  end

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    lane_byte = 8'h00;
    unique case (addr_q[1:0])
      2'b00: lane_byte = dm_rdata[31:24];
      2'b01: lane_byte = dm_rdata[23:16];
      2'b10: lane_byte = dm_rdata[15:8];
      2'b11: lane_byte = dm_rdata[7:0];
    endcase
    lane_half = addr_q[1] ? dm_rdata[15:0] : dm_rdata[31:16];

    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_val = uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_val = dm_rdata;
    endcase

    merge_val = dm_rdata;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'b00: merge_val[31:24] = wdata_q[7:0];
        2'b01: merge_val[23:16] = wdata_q[7:0];
        2'b10: merge_val[15:8]  = wdata_q[7:0];
        2'b11: merge_val[7:0]   = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (addr_q[1]) merge_val[15:0] = wdata_q[15:0];
      else           merge_val[31:16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
            we_q    <= we;
            uns_q   <= uns;
            err_q   <= cap_err;
            if (cap_err)                  state_q <= StDone;
            else if (we && size == 2'b10) state_q <= StWrite;
            else                          state_q <= StRead;
          end
        end
        StRead:  state_q <= StMerge;
        StMerge: begin
          if (we_q) begin
            merged_q <= merge_val;
            state_q  <= StWrite;
          end else begin
            rdata_q <= load_val;
            state_q <= StDone;
          end
        end
        StWrite: state_q <= StDone;
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // All strobes decode from the state register alone.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    err      = done & err_q;
    dm_read  = (state_q == StRead);
    dm_write = (state_q == StWrite);
    dm_addr  = (dm_read | dm_write) ? {addr_q[31:2], 2'b00} : 32'h0;
    if (dm_write) dm_wdata = (size_q == 2'b10) ? wdata_q : merged_q;
    else          dm_wdata = 32'h0;
    rdata    = rdata_q;
  end

endmodule
